line_rasterizer: RTL and testbench
==================================

LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 Parameters: H_RES, default 640, horizontal screen size in pixels; V_RES, default 480, vertical screen size in pixels.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request; sampled only when done=1.
REQ-005 x0, y0  input  12 each  signed two's-complement start point, screen space.
REQ-006 x1, y1  input  12 each  signed two's-complement end point, screen space.
REQ-007 colour  input  3  pixel colour, latched with the endpoints.
REQ-008 plot_ready  input  1  downstream framebuffer writer accepts the current pixel.
REQ-009 plot  output  1  pixel valid.
REQ-010 px  output  10  pixel x, low 10 bits of the current x.
REQ-011 py  output  9  pixel y, low 9 bits of the current y.
REQ-012 pcolour  output  3  latched colour.
REQ-013 done  output  1  high exactly when the state is S_IDLE.

Function
REQ-014 States: S_IDLE, S_SETUP, S_DRAW.
REQ-015 S_IDLE: start=1 latches x0,y0,x1,y1,colour and goes to S_SETUP; otherwise stay in S_IDLE.
REQ-016 start while not in S_IDLE is ignored; the latched endpoints and colour stay unchanged.
REQ-017 S_SETUP (one cycle) sets: cx=x0; cy=y0; dx=|x1-x0|; dy=-|y1-y0|; sx=+1 if x0<x1, else -1; sy=+1 if y0<y1, else -1; err=dx+dy; then go to S_DRAW.
REQ-018 dx, dy, err and the 2*err term are 14-bit signed; all steps are exact with no overflow.
REQ-019 First plot is asserted two cycles after the start cycle.
REQ-020 Visibility: a pixel is visible when 0<=cx<H_RES and 0<=cy<V_RES.
REQ-021 plot = (state==S_DRAW) AND visible.
REQ-022 Pixel consumption: a pixel is consumed when plot AND plot_ready, or on any S_DRAW cycle where the pixel is not visible.
REQ-023 Hold: while plot=1 and plot_ready=0, px, py, pcolour and all internal state are held.
REQ-024 Termination: on consuming a pixel with cx==x1 and cy==y1, go to S_IDLE.
REQ-025 Step: otherwise, on consumption, let e2=2*err.
  - If e2>=dy: err+=dy, cx+=sx.
  - If e2<=dx: err+=dx, cy+=sy.
  - Both updates apply in the same cycle when both conditions hold.
REQ-026 Pixel count per line is max(dx,-dy)+1. With plot_ready held high, one pixel is consumed per cycle.
REQ-027 x0==x1 and y0==y1 yields exactly one pixel.
REQ-028 start asserted in the same cycle that S_DRAW returns to S_IDLE is ignored; done is 0 in that cycle.

Reset
REQ-029 reset forces S_IDLE on the next edge from any state, including mid-line.
REQ-030 Reset values: plot=0, done=1, px=0, py=0, pcolour=0, all internal registers 0.
REQ-031 reset has priority over start.

Configuration
REQ-032 Macro LINE_RASTERIZER_CLIP_EN.
  - Defined: visibility per REQ-020; off-screen pixels are walked but never plotted.
  - Undefined: visible is constant 1; every pixel is plotted with px/py truncated to the low bits; plot_ready stalls every pixel.

Verification
REQ-033 Horizontal line: (0,0)->(3,0), colour=5, plot_ready=1 -> plot=1 with (0,0),(1,0),(2,0),(3,0) on cycles 2..5 after start; pcolour=5; done=1 at cycle 6.
REQ-034 Steep line: (0,0)->(1,3) -> pixels (0,0),(0,1),(1,2),(1,3) in order.
REQ-035 Reversed diagonal: (5,5)->(2,2) -> pixels (5,5),(4,4),(3,3),(2,2); start pulsed mid-line changes nothing.
REQ-036 Backpressure: (10,10)->(12,10) with plot_ready low for 3 cycles at pixel (11,10) -> px=11, py=10 held stable for those cycles; 3 pixels total, no duplicates or drops.
REQ-037 Clipping: (-2,0)->(1,0).
  - With LINE_RASTERIZER_CLIP_EN: only (0,0),(1,0) plotted; done returns 6 cycles after start.
  - Without it: 4 plots, first px=1022.
REQ-038 Reset mid-line: (0,0)->(100,0), reset at the 10th pixel -> next cycle plot=0, done=1, px=0; a following start draws correctly.

Source files
------------

// File: rtl/line_rasterizer.sv
// Bresenham line walker: latches two endpoints, then emits one pixel per accepted handshake.
// Optional screen clipping is enabled by defining LINE_RASTERIZER_CLIP_EN.
module line_rasterizer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [11:0] x0,
    input  logic signed [11:0] y0,
    input  logic signed [11:0] x1,
    input  logic signed [11:0] y1,
    input  logic        [2:0]  colour,
    input  logic               plot_ready,
    output logic               plot,
    output logic        [9:0]  px,
    output logic        [8:0]  py,
    output logic        [2:0]  pcolour,
    output logic               done
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    localparam logic signed [12:0] H_LIM = 13'(H_RES);
    localparam logic signed [12:0] V_LIM = 13'(V_RES);

    state_t             state_reg;
    logic signed [11:0] x0_reg, y0_reg, x1_reg, y1_reg;
    logic signed [11:0] cx_reg, cy_reg;
    logic        [2:0]  colour_reg;
    logic signed [13:0] dx_reg, dy_reg, err_reg;
    logic               sx_neg_reg, sy_neg_reg;

    logic signed [12:0] diff_x, diff_y;
    logic signed [13:0] abs_dx, abs_dy;
    logic signed [13:0] e2, err_step;
    logic               step_x, step_y;
    logic               on_screen, visible, at_end, consume;

    // Differences are taken one bit wider so the magnitude of any 12-bit span is exact.
    assign diff_x = $signed({x1_reg[11], x1_reg}) - $signed({x0_reg[11], x0_reg});
    assign diff_y = $signed({y1_reg[11], y1_reg}) - $signed({y0_reg[11], y0_reg});
    assign abs_dx = diff_x[12] ? -$signed({diff_x[12], diff_x}) : $signed({diff_x[12], diff_x});
    assign abs_dy = diff_y[12] ? -$signed({diff_y[12], diff_y}) : $signed({diff_y[12], diff_y});

    assign e2       = err_reg <<< 1;
    assign step_x   = (e2 >= dy_reg);
    assign step_y   = (e2 <= dx_reg);
    assign err_step = err_reg + (step_x ? dy_reg : 14'sd0) + (step_y ? dx_reg : 14'sd0);

    assign on_screen = !cx_reg[11] && ($signed({cx_reg[11], cx_reg}) < H_LIM) &&
                       !cy_reg[11] && ($signed({cy_reg[11], cy_reg}) < V_LIM);
`ifdef LINE_RASTERIZER_CLIP_EN
    assign visible = on_screen;
`else
    // Unclipped build: every walked pixel is emitted with truncated coordinates.
    assign visible = on_screen | 1'b1;
`endif

    assign at_end  = (cx_reg == x1_reg) && (cy_reg == y1_reg);
    assign plot    = (state_reg == S_DRAW) && visible;
    assign consume = (state_reg == S_DRAW) && (!visible || plot_ready);
    assign done    = (state_reg == S_IDLE);
    assign px      = cx_reg[9:0];
    assign py      = cy_reg[8:0];
    assign pcolour = colour_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            x0_reg     <= '0;
            y0_reg     <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            colour_reg <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        x0_reg     <= x0;
                        y0_reg     <= y0;
                        x1_reg     <= x1;
                        y1_reg     <= y1;
                        colour_reg <= colour;
                        state_reg  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cx_reg     <= x0_reg;
                    cy_reg     <= y0_reg;
                    dx_reg     <= abs_dx;
                    dy_reg     <= -abs_dy;
                    err_reg    <= abs_dx - abs_dy;
                    sx_neg_reg <= !(x0_reg < x1_reg);
                    sy_neg_reg <= !(y0_reg < y1_reg);
                    state_reg  <= S_DRAW;
                end
                S_DRAW: begin
                    if (consume) begin
                        if (at_end) begin
                            state_reg <= S_IDLE;
                        end else begin
                            err_reg <= err_step;
                            if (step_x) cx_reg <= sx_neg_reg ? cx_reg - 12'sd1 : cx_reg + 12'sd1;
                            if (step_y) cy_reg <= sy_neg_reg ? cy_reg - 12'sd1 : cy_reg + 12'sd1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_rasterizer.sv
// Bench for line_rasterizer: directed table, corner sequences and randomized lines
// checked against a plain-integer Bresenham reference model.
module tb_line_rasterizer;
`ifdef LINE_RASTERIZER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif
    localparam int LIMIT = 4000;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               plot_ready = 1'b1;
    logic signed [11:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        [2:0]  colour = '0;
    logic               plot, done;
    logic        [9:0]  px;
    logic        [8:0]  py;
    logic        [2:0]  pcolour;

    int n_tests = 0;
    int n_fail  = 0;
    int got_x[$], got_y[$], got_c[$];
    int exp_x[$], exp_y[$];
    int done_cyc, stalls, hold_err, col_err, glitch_busy, stall_hits;

    typedef struct {
        int x0, y0, x1, y1, col, npix, first_cyc, done_cyc, fx, fy, lx, ly;
    } vec_t;
    vec_t vecs[6];

    line_rasterizer #(.H_RES(640), .V_RES(480)) dut (
        .clock(clock), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour(colour),
        .plot_ready(plot_ready), .plot(plot), .px(px), .py(py),
        .pcolour(pcolour), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: textbook Bresenham over unbounded integers, filtering by the screen.
    function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
        int cx, cy, dx, dy, sx, sy, err, e2;
        exp_x.delete();
        exp_y.delete();
        cx = ax0; cy = ay0;
        dx = iabs(ax1 - ax0); dy = -iabs(ay1 - ay0);
        sx = (ax0 < ax1) ? 1 : -1;
        sy = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        for (int i = 0; i < 20000; i++) begin
            if (!CLIP || (cx >= 0 && cx < 640 && cy >= 0 && cy < 480)) begin
                exp_x.push_back(cx & 1023);
                exp_y.push_back(cy & 511);
            end
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endfunction

    task automatic compare_lists(input string name);
        int bad;
        bad = -1;
        chk({name, "_count"}, got_x.size(), exp_x.size());
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
            if (bad < 0 && (got_x[i] != exp_x[i] || got_y[i] != exp_y[i])) bad = i;
        chk({name, "_first_bad_index"}, bad, -1);
    endtask

    task automatic idle_check(input string name);
        repeat (2) begin
            @(negedge clock);
            chk({name, "_done"}, int'(done), 1);
            chk({name, "_plot"}, int'(plot), 0);
        end
    endtask

    // Cycle 0 is the cycle start is high; outputs of cycle k are sampled on its falling edge.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input int ready_pct, input int glitch_cyc,
                            input int stall_x, input int stall_y, input int stall_len);
        int stall_left;
        logic rdy, holding;
        logic [9:0] hold_px;
        logic [8:0] hold_py;
        got_x.delete(); got_y.delete(); got_c.delete();
        done_cyc = -1; stalls = 0; hold_err = 0; col_err = 0; glitch_busy = -1; stall_hits = 0;
        stall_left = stall_len; holding = 1'b0; hold_px = '0; hold_py = '0;
        @(negedge clock);
        x0 = 12'(ax0); y0 = 12'(ay0); x1 = 12'(ax1); y1 = 12'(ay1);
        colour = 3'(col); start = 1'b1; plot_ready = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= LIMIT; k++) begin
            start = 1'b0;
            if (done) begin done_cyc = k; break; end
            if (holding && (!plot || px != hold_px || py != hold_py)) hold_err++;
            rdy = (int'($urandom_range(99)) < ready_pct);
            if (plot && int'(px) == stall_x && int'(py) == stall_y && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                stall_hits++;
            end
            plot_ready = rdy;
            if (plot) begin
                if (pcolour != 3'(col)) col_err++;
                if (rdy) begin
                    got_x.push_back(int'(px)); got_y.push_back(int'(py)); got_c.push_back(k);
                    holding = 1'b0;
                end else begin
                    stalls++;
                    holding = 1'b1; hold_px = px; hold_py = py;
                end
            end
            if (k == glitch_cyc) begin
                glitch_busy = int'(done);
                x0 = 12'sd50; y0 = 12'sd60; x1 = 12'sd70; y1 = 12'sd90;
                colour = 3'(col + 1); start = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0;
        plot_ready = 1'b1;
        if (done_cyc < 0) chk("timeout", 0, 1);
        $display("[TB] line (%0d,%0d)->(%0d,%0d) col=%0d pixels=%0d stalls=%0d done_cycle=%0d",
                 ax0, ay0, ax1, ay1, col, got_x.size(), stalls, done_cyc);
    endtask

    initial begin
        int found, rx0, ry0, rx1, ry1, rc;
        vecs[0] = '{0, 0, 3, 0, 5, 4, 2, 6, 0, 0, 3, 0};
        vecs[1] = '{0, 0, 1, 3, 1, 4, 2, 6, 0, 0, 1, 3};
        vecs[2] = '{5, 5, 2, 2, 6, 4, 2, 6, 5, 5, 2, 2};
        vecs[3] = '{7, 7, 7, 7, 3, 1, 2, 3, 7, 7, 7, 7};
        vecs[4] = '{10, 20, 4, 17, 2, 7, 2, 9, 10, 20, 4, 17};
        if (CLIP) vecs[5] = '{-2, 0, 1, 0, 4, 2, 4, 6, 0, 0, 1, 0};
        else      vecs[5] = '{-2, 0, 1, 0, 4, 4, 2, 6, 1022, 0, 1, 0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_plot", int'(plot), 0);
        chk("reset_done", int'(done), 1);
        chk("reset_px", int'(px), 0);
        chk("reset_py", int'(py), 0);
        chk("reset_pcolour", int'(pcolour), 0);
        reset = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            model(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
            run_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col, 100, -1, -1, -1, 0);
            compare_lists($sformatf("vec%0d_pixels", i));
            chk($sformatf("vec%0d_npix", i), got_x.size(), vecs[i].npix);
            chk($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].done_cyc);
            chk($sformatf("vec%0d_colour_errs", i), col_err, 0);
            if (got_x.size() > 0) begin
                chk($sformatf("vec%0d_first_cycle", i), got_c[0], vecs[i].first_cyc);
                chk($sformatf("vec%0d_first_px", i), got_x[0], vecs[i].fx);
                chk($sformatf("vec%0d_first_py", i), got_y[0], vecs[i].fy);
                chk($sformatf("vec%0d_last_px", i), got_x[got_x.size()-1], vecs[i].lx);
                chk($sformatf("vec%0d_last_py", i), got_y[got_y.size()-1], vecs[i].ly);
            end
        end

        // Steep line, explicit pixel order
        exp_x = '{0, 0, 1, 1}; exp_y = '{0, 1, 2, 3};
        run_line(0, 0, 1, 3, 2, 100, -1, -1, -1, 0);
        compare_lists("steep");

        // Reversed diagonal with start pulsed mid-line
        exp_x = '{5, 4, 3, 2}; exp_y = '{5, 4, 3, 2};
        run_line(5, 5, 2, 2, 6, 100, 3, -1, -1, 0);
        compare_lists("diag_glitch");
        chk("diag_glitch_busy", glitch_busy, 0);
        chk("diag_glitch_colour_errs", col_err, 0);
        idle_check("diag_glitch_idle");

        // Start in the cycle the line ends is ignored
        exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 0, 0};
        run_line(0, 0, 3, 0, 5, 100, 5, -1, -1, 0);
        compare_lists("end_start");
        chk("end_start_busy", glitch_busy, 0);
        chk("end_start_done_cycle", done_cyc, 6);
        idle_check("end_start_idle");

        // Backpressure at (11,10) for three cycles
        exp_x = '{10, 11, 12}; exp_y = '{10, 10, 10};
        run_line(10, 10, 12, 10, 1, 100, -1, 11, 10, 3);
        compare_lists("backpressure");
        chk("backpressure_stall_hits", stall_hits, 3);
        chk("backpressure_stalls", stalls, 3);
        chk("backpressure_hold_errs", hold_err, 0);
        chk("backpressure_done_cycle", done_cyc, 8);

        // Reset in the middle of a long line
        @(negedge clock);
        x0 = 12'sd0; y0 = 12'sd0; x1 = 12'sd100; y1 = 12'sd0; colour = 3'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (plot && px == 10'd9) begin found = 1; break; end
            @(negedge clock);
        end
        chk("midreset_reached_10th", found, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_plot", int'(plot), 0);
        chk("midreset_done", int'(done), 1);
        chk("midreset_px", int'(px), 0);
        chk("midreset_py", int'(py), 0);
        chk("midreset_pcolour", int'(pcolour), 0);
        reset = 1'b0;
        model(0, 0, 3, 0);
        run_line(0, 0, 3, 0, 5, 100, -1, -1, -1, 0);
        compare_lists("after_reset");
        chk("after_reset_done_cycle", done_cyc, 6);
        $display("[TB] mid-line reset sequence complete");

        // Randomized lines with random backpressure
        for (int t = 0; t < 30; t++) begin
            rx0 = int'($urandom_range(720)) - 40;
            ry0 = int'($urandom_range(560)) - 40;
            rx1 = rx0 + int'($urandom_range(80)) - 40;
            ry1 = ry0 + int'($urandom_range(80)) - 40;
            rc  = int'($urandom_range(7));
            model(rx0, ry0, rx1, ry1);
            run_line(rx0, ry0, rx1, ry1, rc, 70, -1, -1, -1, 0);
            compare_lists($sformatf("rand%0d_pixels", t));
            chk($sformatf("rand%0d_done_cycle", t), done_cyc,
                2 + imax(iabs(rx1 - rx0), iabs(ry1 - ry0)) + 1 + stalls);
            chk($sformatf("rand%0d_hold_errs", t), hold_err, 0);
            chk($sformatf("rand%0d_colour_errs", t), col_err, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
